// File: rtl/lpm_hint_pkg.sv
// lpm_hint_pkg: scan states and ASCII constants shared by the LPM hint evaluator.
package lpm_hint_pkg;
    typedef enum logic [2:0] {IDLE, NAME, SKIP, VALUE, HOLD} state_t;
    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_EQ    = 8'h3D;
endpackage

// File: rtl/lpm_hint_char_class.sv
// lpm_hint_char_class: classifies one hint byte as skippable, entry separator or name/value separator.
module lpm_hint_char_class
    import lpm_hint_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_skip,
    output logic       is_comma,
    output logic       is_eq
);
    assign is_skip  = (ch == CH_NUL) || (ch == CH_SPACE);
    assign is_comma = ch == CH_COMMA;
    assign is_eq    = ch == CH_EQ;
endmodule

// File: rtl/lpm_hint_evaluator.sv
// lpm_hint_evaluator: scans a "NAME=VALUE, ..." hint one byte per clock, MSB first,
// and returns the value of the first entry whose name equals key.
module lpm_hint_evaluator
    import lpm_hint_pkg::*;
#(
    parameter int HINT_CHARS  = 64,
    parameter int NAME_CHARS  = 32,
    parameter int VALUE_CHARS = 32
) (
    input  logic                               clock,
    input  logic                               aclr_n,
    input  logic                               start,
    input  logic [8*HINT_CHARS-1:0]            hint,
    input  logic [8*NAME_CHARS-1:0]            key,
    output logic                               busy,
    output logic                               done,
    output logic                               found,
    output logic [8*VALUE_CHARS-1:0]           value,
    output logic [$clog2(VALUE_CHARS+1)-1:0]   value_len,
    output logic                               value_trunc
);
    localparam int IW = $clog2(HINT_CHARS);
    localparam int NW = $clog2(NAME_CHARS + 1);
    localparam int LW = $clog2(VALUE_CHARS + 1);

    state_t                  state, state_n;
    logic [8*HINT_CHARS-1:0] hint_q;
    logic [8*NAME_CHARS-1:0] key_q, name_buf;
    logic [IW-1:0]           idx;
    logic [NW-1:0]           name_cnt;
    logic                    name_ovf, is_skip, is_comma, is_eq, last, name_hit;
    logic [7:0]              ch;

    assign ch       = hint_q[8*idx +: 8];
    assign last     = idx == '0;
    assign busy     = state != IDLE;
    assign name_hit = (name_buf == key_q) && !name_ovf && (|key_q);

    lpm_hint_char_class u_class (
        .ch       (ch),
        .is_skip  (is_skip),
        .is_comma (is_comma),
        .is_eq    (is_eq)
    );

    always_ff @(posedge clock or negedge aclr_n)
        if (!aclr_n) state <= IDLE;
        else         state <= state_n;

    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = start ? NAME : IDLE;
        else if (last) state_n = IDLE;
        else if (!is_skip)
            case (state)
                NAME:    state_n = is_eq ? (name_hit ? VALUE : SKIP) : NAME;
                SKIP:    state_n = is_comma ? NAME : SKIP;
                VALUE:   state_n = is_comma ? HOLD : VALUE;
                default: state_n = state;
            endcase
    end

    // Datapath follows the same byte stream; the last byte is still consumed before done.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            hint_q      <= '0;
            key_q       <= '0;
            idx         <= '0;
            name_buf    <= '0;
            name_cnt    <= '0;
            name_ovf    <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            value       <= '0;
            value_len   <= '0;
            value_trunc <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    hint_q      <= hint;
                    key_q       <= key;
                    idx         <= IW'(HINT_CHARS - 1);
                    name_buf    <= '0;
                    name_cnt    <= '0;
                    name_ovf    <= 1'b0;
                    found       <= 1'b0;
                    value       <= '0;
                    value_len   <= '0;
                    value_trunc <= 1'b0;
                end
            end else begin
                idx  <= idx - 1'b1;
                done <= last;
                if (!is_skip) begin
                    if (state == NAME && !is_comma && !is_eq) begin
                        name_buf <= {name_buf[8*NAME_CHARS-9:0], ch};
                        name_cnt <= (name_cnt == NW'(NAME_CHARS)) ? name_cnt : name_cnt + 1'b1;
                        name_ovf <= name_ovf | (name_cnt == NW'(NAME_CHARS));
                    end
                    if ((state == NAME || state == SKIP) && (is_comma || is_eq)) begin
                        name_buf <= '0;
                        name_cnt <= '0;
                        name_ovf <= 1'b0;
                    end
                    if (state == NAME && is_eq && name_hit) found <= 1'b1;
                    if (state == VALUE && !is_comma) begin
                        if (value_len < LW'(VALUE_CHARS)) begin
                            value     <= {value[8*VALUE_CHARS-9:0], ch};
                            value_len <= value_len + 1'b1;
                        end else value_trunc <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lpm_hint_evaluator.sv
// tb_lpm_hint_evaluator: directed and random hint strings against an entry-level parsing model,
// on a 32-char-value instance and a 4-char-value instance sharing the same stimulus.
module tb_lpm_hint_evaluator;
    logic         clock = 1'b0;
    logic         aclr_n = 1'b0;
    logic         start = 1'b0;
    logic [511:0] hs = '0;
    logic [255:0] key = '0;
    logic         busy, done, found, value_trunc;
    logic [255:0] value;
    logic [5:0]   value_len;
    logic         busy4, done4, found4, trunc4;
    logic [31:0]  value4;
    logic [2:0]   len4;

    int n_cmp = 0, n_bad = 0;
    int phase = 0;
    logic         ef = 0, ef4 = 0, et = 0, et4 = 0, pf, pf4, pt, pt4;
    logic [255:0] ev = '0, ev4 = '0, pv, pv4;
    int           el = 0, el4 = 0, pl, pl4;

    always #5 clock = ~clock;

    lpm_hint_evaluator #(.HINT_CHARS(64), .NAME_CHARS(32), .VALUE_CHARS(32)) dut (
        .clock(clock), .aclr_n(aclr_n), .start(start), .hint(hs), .key(key),
        .busy(busy), .done(done), .found(found), .value(value),
        .value_len(value_len), .value_trunc(value_trunc)
    );

    lpm_hint_evaluator #(.HINT_CHARS(64), .NAME_CHARS(32), .VALUE_CHARS(4)) dut4 (
        .clock(clock), .aclr_n(aclr_n), .start(start), .hint(hs), .key(key),
        .busy(busy4), .done(done4), .found(found4), .value(value4),
        .value_len(len4), .value_trunc(trunc4)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: strip blanks, split into entries at commas, first '=' splits name from value.
    function automatic void model(input logic [511:0] h, input logic [255:0] k, input int vc,
                                  output logic f, output logic [255:0] v, output int len, output logic tr);
        logic [7:0] cs[$];
        logic [7:0] e[$];
        logic [7:0] b;
        logic [255:0] nb;
        int p;
        f = 0; v = '0; len = 0; tr = 0;
        for (int i = 63; i >= 0; i--) begin
            b = h[8*i +: 8];
            if (b != 8'h00 && b != 8'h20) cs.push_back(b);
        end
        cs.push_back(8'h2C);
        for (int i = 0; i < cs.size(); i++) begin
            if (cs[i] != 8'h2C) begin
                e.push_back(cs[i]);
                continue;
            end
            p = -1;
            for (int j = 0; j < e.size(); j++) if (p < 0 && e[j] == 8'h3D) p = j;
            nb = '0;
            for (int j = 0; j < p; j++) nb = {nb[247:0], e[j]};
            if (!f && p >= 0 && p <= 32 && k != '0 && nb == k) begin
                f = 1;
                for (int j = p + 1; j < e.size(); j++)
                    if (len < vc) begin
                        v = {v[247:0], e[j]};
                        len++;
                    end else tr = 1;
            end
            e.delete();
        end
    endfunction

    // Transaction timing: busy for 64 cycles after an accepted start, then a done cycle.
    always @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            phase = 0;
            ef = 0; ev = '0; el = 0; et = 0;
            ef4 = 0; ev4 = '0; el4 = 0; et4 = 0;
        end else if ((phase == 0 || phase == 65) && start) begin
            phase = 1;
            model(hs, key, 32, pf, pv, pl, pt);
            model(hs, key, 4, pf4, pv4, pl4, pt4);
        end else if (phase >= 1 && phase <= 64) begin
            phase++;
            if (phase == 65) begin
                ef = pf; ev = pv; el = pl; et = pt;
                ef4 = pf4; ev4 = pv4; el4 = pl4; et4 = pt4;
            end
        end else if (phase == 65) phase = 0;
    end

    always @(negedge clock) begin
        logic eb;
        eb = phase >= 1 && phase <= 64;
        chk("busy", busy, eb);
        chk("done", done, phase == 65);
        chk("busy4", busy4, eb);
        chk("done4", done4, phase == 65);
        if (!eb) begin
            chk("found", found, ef);
            chk("value", value, ev);
            chk("value_len", value_len, el);
            chk("value_trunc", value_trunc, et);
            chk("found4", found4, ef4);
            chk("value4", value4, ev4);
            chk("len4", len4, el4);
            chk("trunc4", trunc4, et4);
        end
    end

    task automatic run(input logic [511:0] h, input logic [255:0] k, input int dup,
                       input logic [255:0] k2, output int lat);
        @(posedge clock); #1;
        hs = h; key = k; start = 1;
        @(posedge clock); #1;
        start = 0; lat = 1;
        while (!done && lat < 200) begin
            start = lat == dup;
            if (lat == dup) key = k2;
            @(posedge clock); #1;
            lat++;
        end
        start = 0;
        chk("latency", lat, 65);
    endtask

    function automatic logic [7:0] pick(input int sel);
        case (sel)
            0: pick = 8'h41;
            1: pick = 8'h42;
            2: pick = 8'h3D;
            3: pick = 8'h31;
            default: pick = 8'h20;
        endcase
    endfunction

    function automatic logic [511:0] rand_hint();
        logic [7:0] q[$];
        logic [511:0] h;
        int ne;
        ne = $urandom_range(1, 4);
        for (int n = 0; n < ne; n++) begin
            for (int i = 0; i < $urandom_range(1, 2); i++) q.push_back(pick($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) q.push_back(8'h20);
            if ($urandom_range(0, 9) != 0) q.push_back(8'h3D);
            for (int i = 0; i < $urandom_range(0, 7); i++) q.push_back(pick($urandom_range(0, 4)));
            if (n != ne - 1) q.push_back(8'h2C);
        end
        h = '0;
        for (int i = 0; i < q.size() && i < 64; i++) h = {h[503:0], q[i]};
        return h;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        k = '0;
        for (int i = 0; i < $urandom_range(0, 2); i++) k = {k[247:0], pick($urandom_range(0, 1))};
        return k;
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, d;
        logic [511:0] h;
        logic [255:0] k;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_found", found, 0);
        chk("rst_value", value, 0);
        chk("rst_len", value_len, 0);
        aclr_n = 1;

        run("INPUT_A_IS_CONSTANT=FIXED", "INPUT_A_IS_CONSTANT", 0, 0, lat);
        chk("t1_found", found, 1);
        chk("t1_value", value, "FIXED");
        chk("t1_len", value_len, 5);

        run("INPUT_A_IS_CONSTANT=FIXED, INPUT_A_FIXED_VALUE=0101", "INPUT_A_FIXED_VALUE", 0, 0, lat);
        chk("t2_found", found, 1);
        chk("t2_value", value, "0101");
        chk("t2_len", value_len, 4);

        run("UNUSED", "INPUT_B_IS_CONSTANT", 0, 0, lat);
        chk("t3_found", found, 0);
        chk("t3_value", value, 0);

        run("A=1,A=2,B=", "A", 0, 0, lat);
        chk("t4a_value", value, "1");
        run("A=1,A=2,B=", "B", 0, 0, lat);
        chk("t4b_found", found, 1);
        chk("t4b_len", value_len, 0);
        run("A=1,A=2,B=", "a", 0, 0, lat);
        chk("t4c_found", found, 0);

        run("K=ABCDEFG", "K", 0, 0, lat);
        chk("t5_value4", value4, 32'h41424344);
        chk("t5_trunc4", trunc4, 1);
        chk("t5_len4", len4, 4);
        chk("t5_trunc32", value_trunc, 0);

        h = '0; k = '0;
        for (int i = 0; i < 32; i++) begin h = {h[503:0], 8'h41}; k = {k[247:0], 8'h41}; end
        run({h[495:0], 16'h3D56}, k, 0, 0, lat);
        chk("t6_name32_found", found, 1);
        chk("t6_name32_value", value, "V");
        run({h[487:0], 24'h413D56}, k, 0, 0, lat);
        chk("t6_name33_found", found, 0);

        run("A=X,B=Y", "B", 20, "A", lat);
        chk("t7_busy_start_value", value, "Y");

        @(posedge clock); #1;
        hs = "A=1"; key = "A"; start = 1;
        @(posedge clock); #1;
        start = 0;
        repeat (19) @(posedge clock);
        #1;
        aclr_n = 0;
        #1;
        chk("t8_busy", busy, 0);
        chk("t8_done", done, 0);
        chk("t8_found", found, 0);
        chk("t8_value", value, 0);
        repeat (2) @(posedge clock);
        #1;
        aclr_n = 1;
        d = 0;
        repeat (80) begin
            @(posedge clock); #1;
            if (done) d++;
        end
        chk("t8_no_done", d, 0);

        for (int t = 0; t < 120; t++)
            run(rand_hint(), rand_key(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 63) : 0,
                rand_key(), lat);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lpm_hint_evaluator.md
Name: lpm_hint_evaluator

Overview:
- Sequential parser for LPM hint strings of the form "NAME1=VALUE1, NAME2=VALUE2".
- Given a packed hint string and a key name, it returns the value bound to that key (e.g. INPUT_A_IS_CONSTANT -> "FIXED").
- Used by LPM arithmetic wrappers to decode lpm_hint options at configuration time.
- Scans one character per clock with fixed latency.

Parameters:
- HINT_CHARS, 64: hint string capacity in bytes.
- NAME_CHARS, 32: key and entry-name capacity in bytes.
- VALUE_CHARS, 32: value output capacity in bytes.

Ports:
- clock, input, 1: single clock; all state is rising-edge.
- aclr_n, input, 1: reset. Asynchronous assert, active-low.
- start, input, 1: one-cycle request. Ignored while busy=1.
- hint, input, 8*HINT_CHARS: packed ASCII string. First character is in the most significant non-zero byte. Zero bytes are padding.
- key, input, 8*NAME_CHARS: packed ASCII key name, right-aligned, zero-padded.
- busy, output, 1: scan in progress.
- done, output, 1: one-cycle pulse at end of scan.
- found, output, 1: key matched an entry.
- value, output, 8*VALUE_CHARS: matched value, packed right-aligned, zero-filled. Compares directly against Verilog string literals.
- value_len, output, $clog2(VALUE_CHARS+1): number of characters in value.
- value_trunc, output, 1: matched value exceeded VALUE_CHARS.

Behaviour:
- Reset (aclr_n=0): state IDLE. busy, done, found, value, value_len and value_trunc all 0.
- Reset mid-scan aborts the scan. No done pulse is produced.
- Start accepted in IDLE:
  - hint and key are registered.
  - found, value, value_len and value_trunc are cleared.
  - busy=1 from the next cycle.
- Scan order: byte index HINT_CHARS-1 down to 0, one byte per cycle, always the full string (fixed latency).
- done=1 exactly HINT_CHARS+1 cycles after the start cycle. busy drops in the same cycle.
- Results hold until the next accepted start.
- Character rules:
  - 0x00 (padding) and 0x20 (space) are skipped in every state.
  - ',' terminates the current entry.
  - The first '=' of an entry separates name from value. Any later '=' in the value is a literal character.
- States:
  - IDLE: waits for start.
  - NAME: shifts characters into an entry-name buffer.
    - More than NAME_CHARS characters sets a name-overflow flag.
    - On '=': if buffer equals key, no overflow, and key is non-zero, go to VALUE. Otherwise go to SKIP.
    - On ',': entry had no '='; ignore it, clear buffer, stay in NAME.
  - SKIP: discard characters until ',', then clear buffer and go to NAME.
  - VALUE: shift characters into value; value_len increments.
    - Characters beyond VALUE_CHARS are dropped (the first VALUE_CHARS characters are kept) and set value_trunc.
    - found=1 on entry to VALUE.
    - On ',' go to HOLD.
  - HOLD: ignore the rest of the string. The first matching entry wins.
  - End of string: pulse done and return to IDLE from any scan state.
- Matching is exact and case-sensitive.
- A matched entry with an empty value gives found=1, value_len=0, value=0.
- Key not present, or hint without '=' (e.g. "UNUSED"): found=0, value=0.

Decomposition:
- Package lpm_hint_pkg holds:
  - the state enum (IDLE, NAME, SKIP, VALUE, HOLD);
  - ASCII constants CH_NUL=8'h00, CH_SPACE=8'h20, CH_COMMA=8'h2C, CH_EQ=8'h3D.
- One combinational sub-module, lpm_hint_char_class. It maps a byte to the flags is_skip, is_comma and is_eq.

Test Plan:
- HINT_CHARS=64. hint="INPUT_A_IS_CONSTANT=FIXED", key="INPUT_A_IS_CONSTANT", start -> done exactly 65 cycles later with found=1, value=="FIXED", value_len=5.
- hint="INPUT_A_IS_CONSTANT=FIXED, INPUT_A_FIXED_VALUE=0101", key="INPUT_A_FIXED_VALUE" -> found=1, value=="0101", value_len=4. Spaces are stripped.
- hint="UNUSED", key="INPUT_B_IS_CONSTANT" -> found=0, value=0, value_len=0, done at cycle 65.
- hint="A=1,A=2,B=" -> key "A" gives value=="1" (first match). Key "B" gives found=1, value_len=0. Key "a" gives found=0.
- VALUE_CHARS=4, hint="K=ABCDEFG", key "K" -> value=="ABCD", value_trunc=1.
- Assert aclr_n low at cycle 20 of a scan -> all outputs 0 immediately and no done. A start pulsed while busy=1 is ignored, and its done timing is unaffected.
